// File: rtl/onchip_ram_avl.sv
// onchip_ram_avl
//   Single-port on-chip RAM with an Avalon-MM slave port. After every reset a
//   sequencer fills the whole array with INIT_VALUE (one word per clken cycle)
//   before traffic is accepted.
//   Optional feature macro: ONCHIP_RAM_OUTREG_EN adds an output register stage
//   (read latency 2 instead of 1).
// Ports:
//   clk, reset           single clock, synchronous active-high reset
//   address/byteenable   word address and per-byte write mask
//   chipselect/read/write/writedata  Avalon-MM request
//   clken                clock enable; low stalls accepts, the read pipe and init
//   readdata/readdatavalid  read response (one strobe per accepted read)
//   waitrequest          high while a request cannot be accepted
//   init_done            high once the fill sequence has completed
module onchip_ram_avl #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 10000,
  parameter int unsigned           ADDR_WIDTH = 14,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  output logic                    init_done
);

  localparam int unsigned         BE_W     = DATA_WIDTH / 8;
  localparam int unsigned         IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_A  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic                  init_done_q, init_done_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  in_range, req_ok, wr_acc, rd_acc;
  logic [IDX_W-1:0]      idx;

  logic                  mem_we;
  logic [IDX_W-1:0]      mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_wword, bit_mask;
  logic [BE_W-1:0]       mem_be;

  logic                  v1_q, v1_d;
  logic [DATA_WIDTH-1:0] d1_q, d1_d;
  logic                  out_v;
  logic [DATA_WIDTH-1:0] out_d;
  logic [DATA_WIDTH-1:0] hold_q;

  // Request decode; a read together with a write is dropped.
  assign idx      = address[IDX_W-1:0];
  assign in_range = {1'b0, address} < DEPTH_A;
  assign req_ok   = !reset && clken && (state_q == ST_RUN) && chipselect;
  assign wr_acc   = req_ok && write;
  assign rd_acc   = req_ok && read && !write;

  assign waitrequest   = reset || (state_q != ST_RUN) || !clken;
  // A held stage is only presented on a clken=1 cycle, giving exactly one strobe.
  assign readdatavalid = out_v && clken && !reset;
  // Between strobes the last presented word is held, not the pipe contents.
  assign readdata      = readdatavalid ? out_d : hold_q;
  assign init_done     = init_done_q;

  // Next-state logic and the single RAM write port (init fill or bus write).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    mem_we      = 1'b0;
    mem_addr    = idx;
    mem_wdata   = writedata;
    mem_be      = byteenable;
    case (state_q)
      ST_INIT: begin
        if (clken) begin
          mem_we    = 1'b1;
          mem_addr  = cnt_q;
          mem_wdata = INIT_VALUE;
          mem_be    = '1;
          if (cnt_q == LAST_IDX) begin
            state_d     = ST_RUN;
            init_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      ST_RUN:  mem_we = wr_acc && in_range;
      default: state_d = ST_INIT;
    endcase
    if (reset) mem_we = 1'b0;
  end

  // Byte-merge of the write word.
  always_comb begin
    bit_mask = '0;
    for (int b = 0; b < int'(BE_W); b++) bit_mask[8*b +: 8] = {8{mem_be[b]}};
    mem_wword = (mem[mem_addr] & ~bit_mask) | (mem_wdata & bit_mask);
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wword;
  end

  // Read stage 1. Writes commit at their accepting edge, so a read in the next
  // cycle already sees the new word (write-first).
  always_comb begin
    v1_d = v1_q;
    d1_d = d1_q;
    if (clken) begin
      v1_d = rd_acc;
      if (rd_acc) d1_d = in_range ? mem[idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      v1_q        <= 1'b0;
      d1_q        <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      v1_q        <= v1_d;
      d1_q        <= d1_d;
      if (readdatavalid) hold_q <= out_d;
    end
  end

`ifdef ONCHIP_RAM_OUTREG_EN
  logic                  v2_q;
  logic [DATA_WIDTH-1:0] d2_q;

  // Output register stage; stalls with clken like stage 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      v2_q <= 1'b0;
      d2_q <= '0;
    end else if (clken) begin
      v2_q <= v1_q;
      if (v1_q) d2_q <= d1_q;
    end
  end

  assign out_v = v2_q;
  assign out_d = d2_q;
`else
  assign out_v = v1_q;
  assign out_d = d1_q;
`endif

endmodule

// File: tb/tb_onchip_ram_avl.sv
// tb_onchip_ram_avl
//   Random and directed stimulus for onchip_ram_avl (DEPTH=16, 5-bit address so
//   out-of-range addresses are reachable) checked every cycle against a
//   behavioural model: array contents, init progress and a queue of pending
//   reads, each counting down the clken=1 cycles left until its strobe.
module tb_onchip_ram_avl;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 5;
  localparam logic [31:0] INIT  = 32'hA5A5_A5A5;
`ifdef ONCHIP_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst, ce, cs, rd, wr;
  logic [AW-1:0] addr;
  logic [3:0]    be;
  logic [DW-1:0] wd;
  logic [DW-1:0] readdata;
  logic          readdatavalid, waitrequest, init_done;

  always #5 clk = ~clk;

  onchip_ram_avl #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .INIT_VALUE(INIT)
  ) dut (
    .clk(clk), .reset(rst), .address(addr), .byteenable(be),
    .chipselect(cs), .read(rd), .write(wr), .writedata(wd), .clken(ce),
    .readdata(readdata), .readdatavalid(readdatavalid),
    .waitrequest(waitrequest), .init_done(init_done)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    int          left;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] m_mem [DEPTH];
  bit          m_run  = 1'b0;
  bit          m_done = 1'b0;
  logic [3:0]  m_cnt  = '0;
  logic [31:0] m_last = '0;
  logic [31:0] seen[$];
  bit          e_wait, e_rdv, e_done;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic chk_seen(string name, int i, logic [31:0] exp);
    if (i < seen.size()) chk(name, seen[i], exp);
    else begin
      checks++;
      errors++;
      $display("FAIL %s t=%0t got no strobe #%0d expected %h", name, $time, i, exp);
    end
  endtask

  // Model + compare: outputs of the current cycle, then advance across the edge.
  always @(negedge clk) begin
    e_wait = rst || !m_run || !ce;
    e_done = m_done;
    e_rdv  = 1'b0;
    if (!rst && ce) begin
      foreach (pend[i]) pend[i].left--;
      if (pend.size() > 0 && pend[0].left == 0) begin
        e_rdv  = 1'b1;
        m_last = pend[0].data;
        void'(pend.pop_front());
      end
    end
    chk("waitrequest", 32'(waitrequest), 32'(e_wait));
    chk("readdatavalid", 32'(readdatavalid), 32'(e_rdv));
    if (!rst) begin
      chk("readdata", readdata, m_last);
      chk("init_done", 32'(init_done), 32'(e_done));
    end
    if (readdatavalid) seen.push_back(readdata);

    if (rst) begin
      pend.delete();
      m_run  = 1'b0;
      m_done = 1'b0;
      m_cnt  = '0;
      m_last = '0;
    end else if (!m_run) begin
      if (ce) begin
        m_mem[m_cnt] = INIT;
        if (m_cnt == 4'(DEPTH - 1)) begin
          m_run  = 1'b1;
          m_done = 1'b1;
        end else m_cnt++;
      end
    end else if (ce && cs) begin
      if (wr) begin
        if (32'(addr) < DEPTH)
          for (int b = 0; b < 4; b++)
            if (be[b]) m_mem[addr[3:0]][8*b +: 8] = wd[8*b +: 8];
      end else if (rd) begin
        pend.push_back('{data: (32'(addr) < DEPTH) ? m_mem[addr[3:0]] : 32'h0, left: LAT});
      end
    end
  end

  task automatic step(bit r, bit c_e, bit c_s, bit r_d, bit w_r,
                      logic [AW-1:0] a, logic [3:0] b_e, logic [31:0] w_d);
    @(posedge clk);
    #1;
    rst = r; ce = c_e; cs = c_s; rd = r_d; wr = w_r;
    addr = a; be = b_e; wd = w_d;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 32'd0);
  endtask

  task automatic rst_cyc();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 32'd0);
  endtask

  task automatic rdreq(logic [AW-1:0] a);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, a, 4'd0, 32'd0);
  endtask

  task automatic wrreq(logic [AW-1:0] a, logic [3:0] b, logic [31:0] d);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, a, b, d);
  endtask

  task automatic drain();
    repeat (3) idle();
  endtask

  // Exactly DEPTH busy cycles after reset release, init_done on cycle DEPTH+1.
  task automatic init_seq();
    for (int c = 1; c <= 16; c++) begin
      idle();
      chk("init_wait", 32'(waitrequest), 32'd1);
      chk("init_low", 32'(init_done), 32'd0);
    end
    idle();
    chk("init_done_17", 32'(init_done), 32'd1);
    chk("run_wait", 32'(waitrequest), 32'd0);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0;
    addr = '0; be = '0; wd = '0;
    rst_cyc();
    rst_cyc();
    init_seq();

    seen.delete();
    for (int i = 0; i < 16; i++) rdreq(5'(i));
    drain();
    chk("init_rd_cnt", 32'(seen.size()), 32'd16);
    for (int i = 0; i < 16; i++) chk_seen("init_rd_val", i, INIT);

    wrreq(5'd5, 4'hF, 32'h1122_3344);
    wrreq(5'd5, 4'h5, 32'hFFFF_FFFF);
    seen.delete();
    rdreq(5'd5);
    drain();
    chk_seen("bytemask", 0, 32'h11FF_33FF);

    seen.delete();
    for (int i = 0; i < 8; i++) rdreq(5'(i));
    drain();
    chk("stream_cnt", 32'(seen.size()), 32'd8);
    chk_seen("stream_4", 4, INIT);
    chk_seen("stream_5", 5, 32'h11FF_33FF);

    wrreq(5'd3, 4'hF, 32'hDEAD_BEEF);
    seen.delete();
    rdreq(5'd3);
    wrreq(5'd16, 4'hF, 32'h1234_5678);
    rdreq(5'd16);
    rdreq(5'd0);
    drain();
    chk_seen("wr_then_rd", 0, 32'hDEAD_BEEF);
    chk_seen("oor_read", 1, 32'h0);
    chk_seen("oor_no_alias", 2, INIT);

    seen.delete();
    rdreq(5'd3);
    repeat (3) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 4'd0, 32'd0);
      chk("stall_wait", 32'(waitrequest), 32'd1);
      chk("stall_rdv", 32'(readdatavalid), 32'd0);
    end
`ifndef ONCHIP_RAM_OUTREG_EN
    idle();
    chk("stall_release_rdv", 32'(readdatavalid), 32'd1);
    chk("stall_release_data", readdata, 32'hDEAD_BEEF);
`endif
    drain();
    chk("stall_cnt", 32'(seen.size()), 32'd1);
    chk_seen("stall_data", 0, 32'hDEAD_BEEF);

    seen.delete();
    rdreq(5'd1);
    rst_cyc();
    chk("rst_flush_rdv", 32'(readdatavalid), 32'd0);
    rst_cyc();
    repeat (7) idle();
    rst_cyc();
    init_seq();
    chk("rst_no_strobe", 32'(seen.size()), 32'd0);
    rdreq(5'd3);
    drain();
    chk_seen("refill", 0, INIT);

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 599) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 19)),
           4'($urandom), $urandom);
    end
    repeat (5) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
